// File: rtl/pe_matrix_sched_if.sv
// Descriptor, column/guard control and matrix configuration bundle for pe_matrix_sched.
// master = scheduler side, slave = layer controller / PE matrix side.
interface pe_matrix_sched_if #(
  parameter int NUM_COL = 4
);
  logic               layer_valid;
  logic               layer_ready;
  logic [7:0]         w_num_i;
  logic [7:0]         h_num_i;
  logic [7:0]         c_num_i;
  logic               kernel_mode_i;
  logic               bit_mode_i;
  logic               is_diff_i;
  logic               is_first_i;
  logic [NUM_COL-1:0] col_ctrl_valid;
  logic [NUM_COL-1:0] col_ctrl_ready;
  logic [NUM_COL-1:0] col_ctrl_finish;
  logic               guard_ctrl_valid;
  logic               guard_ctrl_ready;
  logic               guard_ctrl_finish;
  logic [7:0]         w_num_o;
  logic [7:0]         h_num_o;
  logic [7:0]         c_num_o;
  logic               is_diff_o;
  logic               is_first_o;
  logic [NUM_COL-1:0] kernel_mode_o;
  logic [NUM_COL-1:0] bit_mode_o;
  logic [7:0]         pass_idx;
  logic               busy;
  logic               layer_done;

  modport master (
    input  layer_valid, w_num_i, h_num_i, c_num_i,
           kernel_mode_i, bit_mode_i, is_diff_i, is_first_i,
           col_ctrl_ready, col_ctrl_finish, guard_ctrl_ready, guard_ctrl_finish,
    output layer_ready, col_ctrl_valid, guard_ctrl_valid,
           w_num_o, h_num_o, c_num_o, is_diff_o, is_first_o,
           kernel_mode_o, bit_mode_o, pass_idx, busy, layer_done
  );

  modport slave (
    output layer_valid, w_num_i, h_num_i, c_num_i,
           kernel_mode_i, bit_mode_i, is_diff_i, is_first_i,
           col_ctrl_ready, col_ctrl_finish, guard_ctrl_ready, guard_ctrl_finish,
    input  layer_ready, col_ctrl_valid, guard_ctrl_valid,
           w_num_o, h_num_o, c_num_o, is_diff_o, is_first_o,
           kernel_mode_o, bit_mode_o, pass_idx, busy, layer_done
  );
endinterface

// File: rtl/pe_matrix_sched.sv
// Layer scheduler: launches the fm/guard generator once, then runs channel passes of up to
// NUM_COL columns. Define SCHED_PERF_CNT_EN to add the perf_cycles busy-cycle counter.
//
// state        | meaning
// IDLE         | waiting for a layer descriptor (layer_ready high)
// GUARD_LAUNCH | requesting the fm/guard generator
// COL_LAUNCH   | requesting the masked columns of the current pass
// COL_WAIT     | waiting for every masked column to report finish
// GUARD_WAIT   | all passes done, waiting for generator finish
// DONE         | one-cycle layer_done pulse
module pe_matrix_sched #(
  parameter int NUM_COL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pe_matrix_sched_if.master sif
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE, GUARD_LAUNCH, COL_LAUNCH, COL_WAIT, GUARD_WAIT, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         remaining_q, rem_next, take;
  logic [7:0]         pass_idx_q;
  logic [NUM_COL-1:0] mask_q, mask_next, hs_q, fin_q, col_valid;
  logic               gfin_q;
  logic               accept, pass_done, pass_start;

  logic [7:0]         w_num_q, h_num_q, c_num_q;
  logic               is_diff_q, is_first_q;
  logic [NUM_COL-1:0] kernel_mode_q, bit_mode_q;

  // Columns used by the current pass; bounded by remaining so remaining never underflows.
  assign take = (remaining_q > 8'(NUM_COL)) ? 8'(NUM_COL) : remaining_q;

  always_comb begin
    for (int j = 0; j < NUM_COL; j++) begin
      mask_next[j] = (8'(j) < rem_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    col_valid            = '0;
    accept               = 1'b0;
    pass_done            = 1'b0;
    pass_start           = 1'b0;
    rem_next             = remaining_q;
    sif.layer_ready      = 1'b0;
    sif.guard_ctrl_valid = 1'b0;
    sif.busy             = 1'b1;
    sif.layer_done       = 1'b0;
    case (state_q)
      IDLE: begin
        sif.layer_ready = 1'b1;
        sif.busy        = 1'b0;
        if (sif.layer_valid) begin
          accept   = 1'b1;
          rem_next = sif.c_num_i;
          state_d  = (sif.c_num_i == 8'd0) ? DONE : GUARD_LAUNCH;
        end
      end
      GUARD_LAUNCH: begin
        sif.guard_ctrl_valid = 1'b1;
        if (sif.guard_ctrl_ready) begin
          pass_start = 1'b1;
          state_d    = COL_LAUNCH;
        end
      end
      COL_LAUNCH: begin
        col_valid = mask_q & ~hs_q;
        if (((hs_q | (col_valid & sif.col_ctrl_ready)) & mask_q) == mask_q) state_d = COL_WAIT;
      end
      COL_WAIT: begin
        if ((fin_q & mask_q) == mask_q) begin
          pass_done = 1'b1;
          rem_next  = remaining_q - take;
          if (rem_next != 8'd0) begin
            pass_start = 1'b1;
            state_d    = COL_LAUNCH;
          end else begin
            state_d    = GUARD_WAIT;
          end
        end
      end
      GUARD_WAIT: begin
        if (gfin_q) state_d = DONE;
      end
      DONE: begin
        sif.layer_done = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sif.col_ctrl_valid = col_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q   <= '0;
      pass_idx_q    <= '0;
      mask_q        <= '0;
      hs_q          <= '0;
      fin_q         <= '0;
      gfin_q        <= 1'b0;
      w_num_q       <= '0;
      h_num_q       <= '0;
      c_num_q       <= '0;
      is_diff_q     <= 1'b0;
      is_first_q    <= 1'b0;
      kernel_mode_q <= '0;
      bit_mode_q    <= '0;
    end else begin
      if (accept) begin
        remaining_q   <= sif.c_num_i;
        pass_idx_q    <= '0;
        w_num_q       <= sif.w_num_i;
        h_num_q       <= sif.h_num_i;
        c_num_q       <= sif.c_num_i;
        is_diff_q     <= sif.is_diff_i;
        is_first_q    <= sif.is_first_i;
        kernel_mode_q <= {NUM_COL{sif.kernel_mode_i}};
        bit_mode_q    <= {NUM_COL{sif.bit_mode_i}};
      end
      if (pass_done) begin
        remaining_q <= rem_next;
        pass_idx_q  <= pass_idx_q + 8'd1;
      end
      if (pass_start) begin
        mask_q <= mask_next;
        hs_q   <= '0;
        fin_q  <= '0;
      end else begin
        if (state_q == COL_LAUNCH) hs_q <= hs_q | (col_valid & sif.col_ctrl_ready);
        // Finish may land while other columns are still handshaking, or together with ready.
        if (state_q == COL_LAUNCH || state_q == COL_WAIT)
          fin_q <= fin_q | (sif.col_ctrl_finish & mask_q);
      end
      if ((state_q == COL_LAUNCH || state_q == COL_WAIT || state_q == GUARD_WAIT) &&
          sif.guard_ctrl_finish)
        gfin_q <= 1'b1;
      if (state_q == DONE) begin
        gfin_q <= 1'b0;
        fin_q  <= '0;
        hs_q   <= '0;
        mask_q <= '0;
      end
    end
  end

  assign sif.pass_idx      = pass_idx_q;
  assign sif.w_num_o       = w_num_q;
  assign sif.h_num_o       = h_num_q;
  assign sif.c_num_o       = c_num_q;
  assign sif.is_diff_o     = is_diff_q;
  assign sif.is_first_o    = is_first_q;
  assign sif.kernel_mode_o = kernel_mode_q;
  assign sif.bit_mode_o    = bit_mode_q;

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           perf_cycles <= '0;
    else if (accept)                                      perf_cycles <= '0;
    else if (state_q != IDLE && perf_cycles != '1)        perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pe_matrix_sched.sv
// Directed bench for pe_matrix_sched with NUM_COL=4; perf checks only when SCHED_PERF_CNT_EN is set.
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))
module tb_pe_matrix_sched;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  pe_matrix_sched_if #(.NUM_COL(NC)) sif ();
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  pe_matrix_sched #(.NUM_COL(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
`ifdef SCHED_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  logic [NC-1:0] cv_pend;
  logic          gv_pend;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_pend <= '0;
      gv_pend <= 1'b0;
    end else begin
      total++;
      if ((sif.col_ctrl_valid & cv_pend) === cv_pend) passed++;
      else $error("FAIL col valid dropped without ready: valid %0h pend %0h",
                  sif.col_ctrl_valid, cv_pend);
      total++;
      if ((sif.guard_ctrl_valid | ~gv_pend) === 1'b1) passed++;
      else $error("FAIL guard valid dropped without ready");
      total++;
      if (sif.busy === ~sif.layer_ready) passed++;
      else $error("FAIL busy %0b vs layer_ready %0b", sif.busy, sif.layer_ready);
      cv_pend <= sif.col_ctrl_valid & ~sif.col_ctrl_ready;
      gv_pend <= sif.guard_ctrl_valid & ~sif.guard_ctrl_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic desc(input logic [7:0] w, input logic [7:0] h, input logic [7:0] c,
                      input logic km, input logic bm, input logic d, input logic f);
    sif.w_num_i       = w;
    sif.h_num_i       = h;
    sif.c_num_i       = c;
    sif.kernel_mode_i = km;
    sif.bit_mode_i    = bm;
    sif.is_diff_i     = d;
    sif.is_first_i    = f;
    sif.layer_valid   = 1'b1;
  endtask

  // Called in the launch cycle with all readies high; returns in the next launch / GUARD_WAIT cycle.
  task automatic run_pass(input string tag, input logic [3:0] m, input logic [7:0] idx,
                          input logic gpulse);
    `CHK({tag, "_valid"}, sif.col_ctrl_valid, m);
    `CHK({tag, "_idx"}, sif.pass_idx, idx);
    sif.guard_ctrl_finish = gpulse;
    tick();
    sif.guard_ctrl_finish = 1'b0;
    `CHK({tag, "_wait"}, sif.col_ctrl_valid, 4'h0);
    tick();
    tick();
    sif.col_ctrl_finish = 4'hF;
    tick();
    sif.col_ctrl_finish = 4'h0;
    `CHK({tag, "_turn"}, sif.col_ctrl_valid, 4'h0);
    tick();
  endtask

  initial begin
    sif.layer_valid       = 1'b0;
    sif.w_num_i           = '0;
    sif.h_num_i           = '0;
    sif.c_num_i           = '0;
    sif.kernel_mode_i     = 1'b0;
    sif.bit_mode_i        = 1'b0;
    sif.is_diff_i         = 1'b0;
    sif.is_first_i        = 1'b0;
    sif.col_ctrl_ready    = 4'hF;
    sif.col_ctrl_finish   = 4'h0;
    sif.guard_ctrl_ready  = 1'b1;
    sif.guard_ctrl_finish = 1'b0;

    #12;
    `CHK("rst_ready", sif.layer_ready, 1'b1);
    `CHK("rst_busy", sif.busy, 1'b0);
    `CHK("rst_gvalid", sif.guard_ctrl_valid, 1'b0);
    `CHK("rst_cvalid", sif.col_ctrl_valid, 4'h0);
    `CHK("rst_idx", sif.pass_idx, 8'd0);
    `CHK("rst_done", sif.layer_done, 1'b0);
    `CHK("rst_wnum", sif.w_num_o, 8'd0);
    `CHK("rst_kmode", sif.kernel_mode_o, 4'h0);
`ifdef SCHED_PERF_CNT_EN
    `CHK("rst_perf", perf_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic layer: c_num=10 -> masks 1111, 1111, 0011
    desc(8'd10, 8'd20, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    `CHK("b_lready", sif.layer_ready, 1'b1);
    tick();
    sif.layer_valid = 1'b0;
    `CHK("b_gvalid", sif.guard_ctrl_valid, 1'b1);
    `CHK("b_busy", sif.busy, 1'b1);
    `CHK("b_lready_lo", sif.layer_ready, 1'b0);
    `CHK("b_wnum", sif.w_num_o, 8'd10);
    `CHK("b_hnum", sif.h_num_o, 8'd20);
    `CHK("b_cnum", sif.c_num_o, 8'd10);
    `CHK("b_kmode", sif.kernel_mode_o, 4'hF);
    `CHK("b_bmode", sif.bit_mode_o, 4'h0);
    `CHK("b_diff", sif.is_diff_o, 1'b1);
    `CHK("b_first", sif.is_first_o, 1'b0);
    `CHK("b_cvalid_pre", sif.col_ctrl_valid, 4'h0);
    tick();
    `CHK("b_gvalid_lo", sif.guard_ctrl_valid, 1'b0);
    run_pass("b_p0", 4'hF, 8'd0, 1'b0);
    run_pass("b_p1", 4'hF, 8'd1, 1'b0);
    run_pass("b_p2", 4'h3, 8'd2, 1'b0);
    `CHK("b_idx_end", sif.pass_idx, 8'd3);
    `CHK("b_cvalid_gw", sif.col_ctrl_valid, 4'h0);
    `CHK("b_done_gw", sif.layer_done, 1'b0);
    sif.guard_ctrl_finish = 1'b1;
    tick();
    sif.guard_ctrl_finish = 1'b0;
    `CHK("b_done_early", sif.layer_done, 1'b0);
    tick();
    `CHK("b_done", sif.layer_done, 1'b1);
    tick();
    `CHK("b_done_once", sif.layer_done, 1'b0);
    `CHK("b_lready_back", sif.layer_ready, 1'b1);
    `CHK("b_busy_lo", sif.busy, 1'b0);
    `CHK("b_wnum_hold", sif.w_num_o, 8'd10);

    // Zero channels
    desc(8'd7, 8'd9, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    sif.layer_valid = 1'b0;
    `CHK("z_done", sif.layer_done, 1'b1);
    `CHK("z_gvalid", sif.guard_ctrl_valid, 1'b0);
    `CHK("z_cvalid", sif.col_ctrl_valid, 4'h0);
    `CHK("z_wnum", sif.w_num_o, 8'd7);
    `CHK("z_bmode", sif.bit_mode_o, 4'hF);
    `CHK("z_first", sif.is_first_o, 1'b1);
    tick();
    `CHK("z_done_lo", sif.layer_done, 1'b0);
    `CHK("z_lready", sif.layer_ready, 1'b1);

    // Staggered readies 0/1/2/5, finish early on col0 and with ready on col3
    sif.col_ctrl_ready = 4'h0;
    desc(8'd1, 8'd1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    sif.layer_valid = 1'b0;
    tick();
    `CHK("s_v0", sif.col_ctrl_valid, 4'hF);
    sif.col_ctrl_ready = 4'h1;
    tick();
    `CHK("s_v1", sif.col_ctrl_valid, 4'hE);
    sif.col_ctrl_ready  = 4'h3;
    sif.col_ctrl_finish = 4'h1;
    tick();
    sif.col_ctrl_finish = 4'h0;
    `CHK("s_v2", sif.col_ctrl_valid, 4'hC);
    sif.col_ctrl_ready = 4'h4;
    tick();
    `CHK("s_v3", sif.col_ctrl_valid, 4'h8);
    sif.col_ctrl_ready = 4'h0;
    tick();
    `CHK("s_v4", sif.col_ctrl_valid, 4'h8);
    tick();
    `CHK("s_v5", sif.col_ctrl_valid, 4'h8);
    sif.col_ctrl_ready  = 4'h8;
    sif.col_ctrl_finish = 4'h8;
    tick();
    sif.col_ctrl_ready  = 4'hF;
    sif.col_ctrl_finish = 4'h6;
    `CHK("s_v6", sif.col_ctrl_valid, 4'h0);
    `CHK("s_idx6", sif.pass_idx, 8'd0);
    tick();
    sif.col_ctrl_finish = 4'h0;
    `CHK("s_idx7", sif.pass_idx, 8'd0);
    tick();
    `CHK("s_idx8", sif.pass_idx, 8'd1);
    sif.guard_ctrl_finish = 1'b1;
    tick();
    sif.guard_ctrl_finish = 1'b0;
    tick();
    `CHK("s_done", sif.layer_done, 1'b1);
    tick();

    // Early guard finish during pass 0, c_num=5
    desc(8'd2, 8'd2, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    sif.layer_valid = 1'b0;
    tick();
    run_pass("e_p0", 4'hF, 8'd0, 1'b1);
    run_pass("e_p1", 4'h1, 8'd1, 1'b0);
    `CHK("e_idx", sif.pass_idx, 8'd2);
    `CHK("e_done_gw", sif.layer_done, 1'b0);
    `CHK("e_busy_gw", sif.busy, 1'b1);
    tick();
    `CHK("e_done", sif.layer_done, 1'b1);
    tick();
    `CHK("e_lready", sif.layer_ready, 1'b1);

    // Reset during COL_WAIT of pass 1
    desc(8'd3, 8'd3, 8'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    sif.layer_valid = 1'b0;
    tick();
    run_pass("r_p0", 4'hF, 8'd0, 1'b0);
    `CHK("r_v1", sif.col_ctrl_valid, 4'hF);
    tick();
    rst_n = 1'b0;
    #1;
    `CHK("r_cvalid", sif.col_ctrl_valid, 4'h0);
    `CHK("r_busy", sif.busy, 1'b0);
    `CHK("r_lready", sif.layer_ready, 1'b1);
    `CHK("r_idx", sif.pass_idx, 8'd0);
    `CHK("r_wnum", sif.w_num_o, 8'd0);
    `CHK("r_kmode", sif.kernel_mode_o, 4'h0);
    `CHK("r_diff", sif.is_diff_o, 1'b0);
    `CHK("r_done", sif.layer_done, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    desc(8'd4, 8'd5, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    `CHK("r2_lready", sif.layer_ready, 1'b1);
    tick();
    sif.layer_valid = 1'b0;
    `CHK("r2_gvalid", sif.guard_ctrl_valid, 1'b1);
    `CHK("r2_wnum", sif.w_num_o, 8'd4);
    `CHK("r2_cnum", sif.c_num_o, 8'd1);
    tick();
    `CHK("r2_cvalid", sif.col_ctrl_valid, 4'h1);
    tick();
    sif.col_ctrl_finish   = 4'h1;
    sif.guard_ctrl_finish = 1'b1;
    tick();
    sif.col_ctrl_finish   = 4'h0;
    sif.guard_ctrl_finish = 1'b0;
    `CHK("r2_done_a", sif.layer_done, 1'b0);
    tick();
    `CHK("r2_done_b", sif.layer_done, 1'b0);
    tick();
    `CHK("r2_done", sif.layer_done, 1'b1);
    tick();

`ifdef SCHED_PERF_CNT_EN
    // c_num=4, finish 10 cycles after launch: accept-to-done is 16 cycles
    desc(8'd1, 8'd1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    sif.layer_valid = 1'b0;
    `CHK("p_clear", perf_cycles, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) tick();
    sif.col_ctrl_finish = 4'hF;
    tick();
    sif.col_ctrl_finish = 4'h0;
    tick();
    sif.guard_ctrl_finish = 1'b1;
    tick();
    sif.guard_ctrl_finish = 1'b0;
    tick();
    `CHK("p_done", sif.layer_done, 1'b1);
    tick();
    `CHK("p_count", perf_cycles, 32'd16);
    tick();
    tick();
    tick();
    `CHK("p_hold", perf_cycles, 32'd16);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
